fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of one FIFO instance among NUM_REQ producers.
- Each producer has a valid/ready handshake.
- Keeps its own occupancy credit count from issued writes and monitored reads, so it never overruns the FIFO despite the FIFO's registered (one-cycle-late) full flag.
- Optional burst hold: a granted producer keeps the port for up to MAX_BURST consecutive beats.

Parameters:
- NUM_REQ, 4, number of producers (2..16).
- DATA_WIDTH, 16, FIFO data width.
- DATA_DEPTH, 1024, FIFO depth (power of 2); also the credit limit.
- MAX_BURST, 4, max consecutive beats per grant (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- req_valid  in  NUM_REQ  per-producer data valid
- req_data  in  NUM_REQ*DATA_WIDTH  producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant; combinational
- fifo_write  out  1  write strobe to FIFO (registered)
- fifo_data  out  DATA_WIDTH  write data to FIFO (registered)
- fifo_read  in  1  copy of consumer read strobe driven to the FIFO
- occupancy  out  clog2(DATA_DEPTH)+1  committed + pending entries
- grant_id  out  clog2(NUM_REQ)  index of current/last granted producer
- busy  out  1  high while in BURST state

Behaviour:
- Reset: everything takes effect on the rising clk edge with rst==0.
  - Outputs: fifo_write=0, fifo_data=0, occupancy=0, grant_id=0, busy=0, req_ready=0.
  - State: FSM=IDLE, rr pointer=NUM_REQ-1 (so producer 0 has first priority), beat counter=0.
  - Reset mid-burst aborts the burst. A beat handshaken in the reset cycle is dropped and fifo_write stays low.
- Credit rule: can_accept = (occupancy < DATA_DEPTH). Reads in the same cycle are not credited; this is conservative.
- Handshake: transfer occurs when req_valid[i] && req_ready[i]. Producers must not gate valid on ready. Data must be held until transfer.
- Write latency: a transfer in cycle T gives fifo_write=1 and fifo_data=that beat in cycle T+1. Otherwise fifo_write=0 and fifo_data=0.
- Occupancy update each cycle:
  - +1 on transfer.
  - -1 when fifo_read && (occupancy - fifo_write) != 0; reads against an actually empty FIFO are ignored.
  - Both events in one cycle: no change.
  - Never exceeds DATA_DEPTH; never underflows.
- FSM:
  - IDLE:
    - If can_accept and any valid: pick the first valid index searching rr+1, rr+2, ... modulo NUM_REQ.
    - Assert its ready (same cycle); grant_id <= index; beat counter <= 1.
    - If MAX_BURST>1, go to BURST; else rr <= index and stay in IDLE.
  - BURST, owner = grant_id:
    - req_ready[owner] = req_valid[owner] && can_accept; other readies are 0.
    - On each transfer, beat counter increments.
    - Leave to IDLE with rr <= owner when either:
      - beat counter reaches MAX_BURST on a transfer, or
      - owner drops valid (no transfer that cycle).
    - can_accept==0 stalls in BURST; ownership is not lost.
- Fairness: no producer waits more than (NUM_REQ-1)*MAX_BURST transfers while valid and credit are available.
- Wrap-around: the rr search wraps from NUM_REQ-1 to 0. The occupancy counter is one bit wider than the index, so it represents DATA_DEPTH exactly.
- At most one bit of req_ready is high in any cycle.

Decomposition:
- Shared package fifo_pkg:
  - FSM state typedef {IDLE, BURST}.
  - Function clog2_safe.
  - Constant OCC_W = clog2(DATA_DEPTH)+1.
- One sub-module: rr_priority_pick.
  - Combinational, NUM_REQ-wide.
  - Inputs: valid vector, rr pointer.
  - Outputs: one-hot grant, index, any.

Test Plan:
- Reset/idle: rst low 3 cycles with all req_valid=1 -> req_ready=0, fifo_write=0, occupancy=0. After release, producer 0 granted first and grant_id=0.
- Round robin: NUM_REQ=4, MAX_BURST=1, all valid continuously -> grant order 0,1,2,3,0,1; fifo_data follows each producer's data one cycle later.
- Burst hold: MAX_BURST=4, producers 1 and 2 valid -> four beats from 1, then four from 2. If producer 1 drops valid after 2 beats -> switch to 2 the next cycle.
- Full/credit: DATA_DEPTH=8, no reads, continuous valid -> exactly 8 transfers, occupancy=8, req_ready stays 0. One fifo_read pulse -> occupancy 7 -> one more transfer -> occupancy back to 8.
- Simultaneous read+write at occupancy=5 -> occupancy stays 5. fifo_read at occupancy=0 -> stays 0.
- Mid-burst reset: rst low on the 2nd beat of a burst -> no fifo_write in the next cycle, FSM=IDLE. After release, producer 0 priority restored.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of an index into n items; never returns zero so 1-bit buses stay legal.
  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_DEPTH = 1024;
  localparam int OCC_W         = clog2_safe(DEFAULT_DEPTH) + 1;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first valid requester after the rr pointer, wrapping.
module rr_priority_pick
  import fifo_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = clog2_safe(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  // NOTE: every output gets a default before the loop so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    grant   = '0;
    index   = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      pos = int'(rr) + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!any && valid[pos_idx]) begin
        any            = 1'b1;
        grant[pos_idx] = 1'b1;
        index          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with credit-based overrun protection and optional burst hold.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int DATA_DEPTH = 1024,
  parameter  int MAX_BURST  = 4,
  localparam int IDX_W      = clog2_safe(NUM_REQ),
  localparam int OCC_BITS   = clog2_safe(DATA_DEPTH) + 1,
  localparam int BEAT_W     = clog2_safe(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_read,
  output logic [OCC_BITS-1:0]           occupancy,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy
);

  arb_state_t             state, state_next;
  logic [IDX_W-1:0]       rr_ptr;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [NUM_REQ-1:0]     pick_grant;
  logic [IDX_W-1:0]       pick_index;
  logic                   pick_any;
  logic [IDX_W-1:0]       xfer_index;
  logic [DATA_WIDTH-1:0]  xfer_data;
  logic                   can_accept;
  logic                   transfer;
  logic                   release_grant;
  logic                   rd_credit;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid),
    .rr    (rr_ptr),
    .grant (pick_grant),
    .index (pick_index),
    .any   (pick_any)
  );

  assign can_accept = (occupancy < OCC_BITS'(DATA_DEPTH));
  assign transfer   = |(req_valid & req_ready);
  assign xfer_data  = req_data[int'(xfer_index)*DATA_WIDTH +: DATA_WIDTH];
  assign busy       = (state == BURST);
  // The pending write (fifo_write) is not yet in the FIFO, so it cannot be read out.
  assign rd_credit  = fifo_read && (occupancy != OCC_BITS'(fifo_write));

  // Ready is gated by reset so no beat can be handshaken during the reset cycle.
  always_comb begin
    req_ready     = '0;
    state_next    = state;
    release_grant = 1'b0;
    xfer_index    = grant_id;
    if (rst) begin
      if (state == IDLE) begin
        xfer_index = pick_index;
        if (can_accept && pick_any) begin
          req_ready = pick_grant;
          if (MAX_BURST > 1) state_next = BURST;
        end
      end else begin
        req_ready[grant_id] = req_valid[grant_id] && can_accept;
        if (!req_valid[grant_id]) begin
          state_next    = IDLE;
          release_grant = 1'b1;
        end else if (can_accept && (beat_cnt == BEAT_W'(MAX_BURST - 1))) begin
          state_next    = IDLE;
          release_grant = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= IDX_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
      grant_id   <= '0;
      occupancy  <= '0;
      fifo_write <= 1'b0;
      fifo_data  <= '0;
    end else begin
      state      <= state_next;
      fifo_write <= transfer;
      fifo_data  <= transfer ? xfer_data : '0;

      if (transfer && !rd_credit)      occupancy <= occupancy + 1'b1;
      else if (!transfer && rd_credit) occupancy <= occupancy - 1'b1;

      if (state == IDLE) begin
        if (transfer) begin
          grant_id <= pick_index;
          beat_cnt <= BEAT_W'(1);
          if (MAX_BURST == 1) rr_ptr <= pick_index;
        end
      end else begin
        if (transfer) beat_cnt <= beat_cnt + 1'b1;
        if (release_grant) begin
          rr_ptr   <= grant_id;
          beat_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: dut_a (depth 8, single-beat) and dut_b (depth 1024, burst of 4).
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic        fifo_read;

  logic [3:0]  ready_a, ready_b;
  logic        write_a, write_b;
  logic [15:0] data_a, data_b;
  logic [3:0]  occ_a;
  logic [10:0] occ_b;
  logic [1:0]  grant_a, grant_b;
  logic        busy_a, busy_b;

  int n_vec = 0;
  int n_err = 0;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .DATA_DEPTH(8), .MAX_BURST(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_a), .fifo_write(write_a), .fifo_data(data_a),
    .fifo_read(fifo_read), .occupancy(occ_a), .grant_id(grant_a), .busy(busy_a)
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .DATA_DEPTH(1024), .MAX_BURST(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_b), .fifo_write(write_b), .fifo_data(data_b),
    .fifo_read(fifo_read), .occupancy(occ_b), .grant_id(grant_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_data(input int i);
    return 16'hA500 | 16'(i);
  endfunction

  initial begin
    rst       = 1'b0;
    req_valid = 4'hF;
    fifo_read = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = exp_data(i);

    // Reset held with every producer valid
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", 32'(ready_a), 32'h0);
      check("rst_write", 32'(write_a), 32'h0);
      check("rst_occ",   32'(occ_a),   32'h0);
    end
    rst = 1'b1;
    #1;
    check("first_ready", 32'(ready_a), 32'h1);
    check("first_grant", 32'(grant_a), 32'h0);

    // Round robin then fill to depth 8
    for (int k = 0; k < 8; k++) begin
      check("rr_ready", 32'(ready_a), 32'(1 << (k % 4)));
      tick();
      check("rr_write", 32'(write_a), 32'h1);
      check("rr_data",  32'(data_a),  32'(exp_data(k % 4)));
      check("rr_grant", 32'(grant_a), 32'(k % 4));
      check("rr_occ",   32'(occ_a),   32'(k + 1));
      #1;
    end
    check("full_ready", 32'(ready_a), 32'h0);
    tick();
    check("full_write", 32'(write_a), 32'h0);
    check("full_occ",   32'(occ_a),   32'h8);
    check("full_ready2", 32'(ready_a), 32'h0);

    // One read frees one credit
    fifo_read = 1'b1;
    tick();
    fifo_read = 1'b0;
    #1;
    check("rd_occ7",   32'(occ_a),   32'h7);
    check("rd_ready",  32'(ready_a), 32'h1);
    tick();
    check("refill_occ",   32'(occ_a),   32'h8);
    check("refill_write", 32'(write_a), 32'h1);
    check("refill_data",  32'(data_a),  32'(exp_data(0)));
    check("refill_ready", 32'(ready_a), 32'h0);

    // Drain to 5, then simultaneous read and write
    req_valid = 4'h0;
    fifo_read = 1'b1;
    repeat (3) tick();
    check("drain_occ5", 32'(occ_a), 32'h5);
    req_valid = 4'hF;
    #1;
    check("rw_ready", 32'(ready_a), 32'h2);
    tick();
    check("rw_occ",   32'(occ_a),   32'h5);
    check("rw_write", 32'(write_a), 32'h1);
    check("rw_data",  32'(data_a),  32'(exp_data(1)));
    fifo_read = 1'b0;
    req_valid = 4'h0;

    // Read against empty FIFO
    rst = 1'b0;
    tick();
    rst = 1'b1;
    fifo_read = 1'b1;
    tick();
    check("empty_rd_occ", 32'(occ_a), 32'h0);
    tick();
    check("empty_rd_occ2", 32'(occ_a), 32'h0);
    fifo_read = 1'b0;

    // Burst hold: four beats from 1, four from 2, then back to 1
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req_valid = 4'b0110;
    #1;
    for (int c = 0; c < 8; c++) begin
      int owner;
      owner = (c < 4) ? 1 : 2;
      check("burst_ready", 32'(ready_b), 32'(1 << owner));
      check("burst_busy",  32'(busy_b),  32'((c % 4) != 0));
      tick();
      check("burst_data",  32'(data_b),  32'(exp_data(owner)));
      check("burst_grant", 32'(grant_b), 32'(owner));
      #1;
    end
    check("burst_wrap_ready", 32'(ready_b), 32'h2);
    check("burst_occ", 32'(occ_b), 32'h8);

    // Owner drops valid after two beats
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req_valid = 4'b0110;
    #1;
    check("drop_ready0", 32'(ready_b), 32'h2);
    tick();
    #1;
    check("drop_ready1", 32'(ready_b), 32'h2);
    tick();
    req_valid = 4'b0100;
    #1;
    check("drop_ready2", 32'(ready_b), 32'h0);
    check("drop_busy2",  32'(busy_b),  32'h1);
    tick();
    check("drop_write", 32'(write_b), 32'h0);
    check("drop_busy3", 32'(busy_b),  32'h0);
    #1;
    check("drop_switch", 32'(ready_b), 32'h4);

    // Reset on the second beat of a burst
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req_valid = 4'b0110;
    #1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready_b), 32'h0);
    tick();
    check("mid_rst_write", 32'(write_b), 32'h0);
    check("mid_rst_busy",  32'(busy_b),  32'h0);
    check("mid_rst_occ",   32'(occ_b),   32'h0);
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    check("post_rst_ready", 32'(ready_b), 32'h1);
    tick();
    check("post_rst_grant", 32'(grant_b), 32'h0);
    check("post_rst_data",  32'(data_b),  32'(exp_data(0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
